// File: rtl/alu_pkg.sv
// Shared ALU types: function codes, captured flag bundle and the arbiter FSM
// state, plus the wrap helper that the round-robin search uses.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_func_e;

  typedef struct packed {
    logic zero;
    logic positive;
    logic carry;
    logic signed_overflow;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  // Index reached by stepping 'offset' places from 'base' in a ring of n.
  function automatic int rr_wrap(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the shared ALU arbiter: operation requests in,
// one shared result/flag bus out with a per-requester response handshake.
interface alu_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 2
);
  import alu_pkg::*;

  localparam int FUNC_W = $bits(alu_func_e);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*FUNC_W-1:0] req_func;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_result;
  alu_flags_t              rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_func, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_func, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/alu.sv
// Shared combinational ALU; the result bus is only driven while enabled so
// several masters could share it.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  alu_func_e         func,
  input  logic              output_enable,
  output wire  [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              positive_flag,
  output logic              carry_flag,
  output logic              signed_overflow
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] value;

  // Carry is the unsigned carry-out for ADD and the borrow for SUB; unnamed
  // function codes yield zero.
  always_comb begin
    wide            = '0;
    signed_overflow = 1'b0;
    case (func)
      ALU_ADD: begin
        wide            = {1'b0, operand_a} + {1'b0, operand_b};
        signed_overflow = (operand_a[MSB] == operand_b[MSB]) && (wide[MSB] != operand_a[MSB]);
      end
      ALU_SUB: begin
        wide            = {1'b0, operand_a} - {1'b0, operand_b};
        signed_overflow = (operand_a[MSB] != operand_b[MSB]) && (wide[MSB] != operand_a[MSB]);
      end
      ALU_AND: wide = {1'b0, operand_a & operand_b};
      ALU_OR:  wide = {1'b0, operand_a | operand_b};
      ALU_XOR: wide = {1'b0, operand_a ^ operand_b};
      default: wide = '0;
    endcase
  end

  assign value         = wide[MSB:0];
  assign carry_flag    = wide[DATA_W];
  assign zero_flag     = (value == '0);
  assign positive_flag = !value[MSB] && (value != '0);
  assign result        = output_enable ? value : {DATA_W{1'bz}};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request found when walking
// upward from ptr with wrap-around.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] request,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back toward ptr so the closest hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'(rr_wrap(int'(ptr), off, N_REQ));
      if (request[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin accept, one cycle of ALU
// execution, then a held response until the issuing requester takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output alu_func_e         alu_func,
  output logic              alu_output_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero_flag,
  input  logic              positive_flag,
  input  logic              carry_flag,
  input  logic              signed_overflow
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int FUNC_W = $bits(alu_func_e);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic [N_REQ-1:0]  rr_grant;
  logic [IDX_W-1:0]  rr_idx;
  logic              rr_any;
  logic              accept;
  logic [N_REQ-1:0]  req_ready_c;
  logic [N_REQ-1:0]  rsp_valid_c;
  logic [DATA_W-1:0] rsp_result_q;
  alu_flags_t        rsp_flags_q;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr (
    .request  (bus.req_valid),
    .ptr      (ptr_q),
    .grant    (rr_grant),
    .grant_idx(rr_idx),
    .any      (rr_any)
  );

  // No accept is offered while reset is held, so nobody sees a phantom grant.
  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    req_ready_c       = '0;
    rsp_valid_c       = '0;
    alu_output_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_any && !rst) begin
          req_ready_c = rr_grant;
          accept      = 1'b1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        alu_output_enable = 1'b1;
        state_d           = RESP;
      end
      RESP: begin
        rsp_valid_c[grant_q] = 1'b1;
        if (bus.rsp_ready[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The ALU bus is only sampled in EXEC, the one cycle it is actively driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_func      <= ALU_ADD;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q       <= rr_idx;
        ptr_q         <= IDX_W'(rr_wrap(int'(rr_idx), 1, N_REQ));
        alu_operand_a <= bus.req_a[int'(rr_idx)*DATA_W +: DATA_W];
        alu_operand_b <= bus.req_b[int'(rr_idx)*DATA_W +: DATA_W];
        alu_func      <= alu_func_e'(bus.req_func[int'(rr_idx)*FUNC_W +: FUNC_W]);
      end
      if (state_q == EXEC) begin
        rsp_result_q <= alu_result;
        rsp_flags_q  <= {zero_flag, positive_flag, carry_flag, signed_overflow};
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter driving the shared alu: directed handshake scenarios
// followed by randomized traffic checked against an arithmetic reference.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DATA_W = 8;
  localparam int N_REQ  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] alu_operand_a;
  logic [DATA_W-1:0] alu_operand_b;
  alu_func_e         alu_func;
  logic              alu_output_enable;
  wire  [DATA_W-1:0] alu_result;
  logic              zero_flag;
  logic              positive_flag;
  logic              carry_flag;
  logic              signed_overflow;

  int checks = 0;
  int errors = 0;
  int en_count = 0;

  logic [7:0] op_a [N_REQ];
  logic [7:0] op_b [N_REQ];
  logic [2:0] op_f [N_REQ];

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(DATA_W), .N_REQ(N_REQ)) bus ();

  alu_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .alu_operand_a    (alu_operand_a),
    .alu_operand_b    (alu_operand_b),
    .alu_func         (alu_func),
    .alu_output_enable(alu_output_enable),
    .alu_result       (alu_result),
    .zero_flag        (zero_flag),
    .positive_flag    (positive_flag),
    .carry_flag       (carry_flag),
    .signed_overflow  (signed_overflow)
  );

  alu #(.DATA_W(DATA_W)) u_alu (
    .operand_a      (alu_operand_a),
    .operand_b      (alu_operand_b),
    .func           (alu_func),
    .output_enable  (alu_output_enable),
    .result         (alu_result),
    .zero_flag      (zero_flag),
    .positive_flag  (positive_flag),
    .carry_flag     (carry_flag),
    .signed_overflow(signed_overflow)
  );

  always @(negedge clk) begin
    if (alu_output_enable === 1'b1) en_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result as {zero, positive, carry, overflow, result[7:0]}.
  function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] f);
    int u, s;
    logic [7:0] res;
    logic c, o;
    u = 0; s = 0; c = 1'b0;
    case (f)
      3'd0: begin u = int'(a) + int'(b); s = int'($signed(a)) + int'($signed(b)); c = (u > 255); end
      3'd1: begin u = int'(a) - int'(b); s = int'($signed(a)) - int'($signed(b)); c = (u < 0); end
      3'd2: u = int'(a & b);
      3'd3: u = int'(a | b);
      3'd4: u = int'(a ^ b);
      default: u = 0;
    endcase
    res = u[7:0];
    o = (s > 127) || (s < -128);
    return {res == 8'h00, (res != 8'h00) && (res < 8'h80), c, o, res};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_stimulus(input int idx, input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] f);
    op_a[idx] = a;
    op_b[idx] = b;
    op_f[idx] = f;
    bus.req_a[idx*8 +: 8]    = a;
    bus.req_b[idx*8 +: 8]    = b;
    bus.req_func[idx*3 +: 3] = f;
    bus.req_valid[idx]       = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    check_output({tag, ".req_ready"}, 32'(bus.req_ready), 32'(0));
    check_output({tag, ".rsp_result"}, 32'(bus.rsp_result), 32'(0));
    check_output({tag, ".rsp_flags"}, 32'(bus.rsp_flags), 32'(0));
    check_output({tag, ".operand_a"}, 32'(alu_operand_a), 32'(0));
    check_output({tag, ".operand_b"}, 32'(alu_operand_b), 32'(0));
    check_output({tag, ".func"}, 32'(alu_func), 32'(ALU_ADD));
    check_output({tag, ".oe"}, 32'(alu_output_enable), 32'(0));
  endtask

  // Accept of requester idx in this cycle, EXEC, RESP taken immediately.
  task automatic expect_op(input int idx, input logic [11:0] exp, input string tag);
    int base;
    settle();
    check_output({tag, ".req_ready"}, 32'(bus.req_ready), 32'(1) << idx);
    tick();
    bus.req_valid[idx] = 1'b0;
    base = en_count;
    settle();
    check_output({tag, ".exec_oe"}, 32'(alu_output_enable), 32'(1));
    check_output({tag, ".exec_a"}, 32'(alu_operand_a), 32'(op_a[idx]));
    check_output({tag, ".exec_b"}, 32'(alu_operand_b), 32'(op_b[idx]));
    check_output({tag, ".exec_func"}, 32'(alu_func), 32'(op_f[idx]));
    check_output({tag, ".exec_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    tick();
    settle();
    check_output({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(1) << idx);
    check_output({tag, ".rsp_result"}, 32'(bus.rsp_result), 32'(exp[7:0]));
    check_output({tag, ".rsp_flags"}, 32'(bus.rsp_flags), 32'(exp[11:8]));
    check_output({tag, ".resp_oe"}, 32'(alu_output_enable), 32'(0));
    tick();
    settle();
    check_output({tag, ".idle_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    check_output({tag, ".oe_cycles"}, 32'(en_count - base), 32'(1));
  endtask

  initial begin
    int base;
    int pending [N_REQ];
    int wait_turns [N_REQ];
    int model_ptr, model_idx, model_phase, winner, drop_idx, ops_done;
    bit model_busy;
    logic [11:0] model_exp;
    logic [7:0] model_a, model_b;
    logic [2:0] model_f;

    rst           = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_func  = '0;
    bus.rsp_ready = 2'b00;
    tick();
    tick();
    settle();
    check_reset_values("reset");
    bus.req_valid = 2'b00;
    rst = 1'b0;
    tick();
    settle();
    check_output("post_reset.rsp_valid", 32'(bus.rsp_valid), 32'(0));

    $display("[TB] single request");
    bus.rsp_ready = 2'b11;
    apply_stimulus(0, 8'h10, 8'h20, ALU_ADD);
    expect_op(0, {4'b0100, 8'h30}, "single");

    $display("[TB] back-to-back with fairness");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    apply_stimulus(0, 8'h7F, 8'h01, ALU_ADD);
    apply_stimulus(1, 8'h00, 8'h01, ALU_SUB);
    expect_op(0, {4'b0001, 8'h80}, "b2b.req0");
    apply_stimulus(0, 8'h05, 8'h03, ALU_ADD);
    expect_op(1, {4'b0010, 8'hFF}, "b2b.req1");
    expect_op(0, {4'b0100, 8'h08}, "b2b.fair");

    $display("[TB] response backpressure");
    bus.rsp_ready = 2'b10;
    apply_stimulus(0, 8'h44, 8'h11, ALU_ADD);
    settle();
    check_output("bp.accept", 32'(bus.req_ready), 32'(1));
    tick();
    bus.req_valid[0] = 1'b0;
    apply_stimulus(1, 8'hC8, 8'h0F, ALU_AND);
    base = en_count;
    tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      check_output("bp.rsp_valid", 32'(bus.rsp_valid), 32'(1));
      check_output("bp.rsp_result", 32'(bus.rsp_result), 32'(8'h55));
      check_output("bp.rsp_flags", 32'(bus.rsp_flags), 32'(4'b0100));
      check_output("bp.req_ready", 32'(bus.req_ready), 32'(0));
      check_output("bp.oe_cycles", 32'(en_count - base), 32'(1));
      tick();
    end
    bus.rsp_ready = 2'b01;
    settle();
    check_output("bp.release_valid", 32'(bus.rsp_valid), 32'(1));
    tick();
    settle();
    check_output("bp.idle_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check_output("bp.idle_req_ready", 32'(bus.req_ready), 32'(2));
    bus.rsp_ready = 2'b11;
    expect_op(1, {4'b0100, 8'h08}, "bp.req1");

    $display("[TB] reset during EXEC");
    apply_stimulus(0, 8'hAA, 8'h55, ALU_XOR);
    settle();
    check_output("rst.accept", 32'(bus.req_ready), 32'(1));
    tick();
    bus.req_valid[0] = 1'b0;
    rst = 1'b1;
    settle();
    check_output("rst.exec_oe", 32'(alu_output_enable), 32'(1));
    tick();
    settle();
    check_reset_values("rst.abort");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      check_output("rst.no_rsp", 32'(bus.rsp_valid), 32'(0));
    end
    apply_stimulus(0, 8'h01, 8'h01, ALU_ADD);
    apply_stimulus(1, 8'h02, 8'h02, ALU_ADD);
    expect_op(0, {4'b0100, 8'h02}, "rst.ptr0");
    expect_op(1, {4'b0100, 8'h04}, "rst.next");

    $display("[TB] randomized traffic");
    bus.req_valid = 2'b00;
    pending    = '{0, 0};
    wait_turns = '{0, 0};
    model_ptr = 0; model_idx = 0; model_phase = 0; drop_idx = -1; ops_done = 0;
    model_busy = 1'b0; model_exp = '0; model_a = '0; model_b = '0; model_f = '0;
    for (int cyc = 0; cyc < 3000 && ops_done < 100; cyc++) begin
      if (drop_idx >= 0) begin
        bus.req_valid[drop_idx] = 1'b0;
        drop_idx = -1;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (pending[i] == 0 && $urandom_range(0, 3) != 0) begin
          apply_stimulus(i, 8'($urandom()), 8'($urandom()), 3'($urandom()));
          pending[i]    = 1;
          wait_turns[i] = 0;
        end
      end
      bus.rsp_ready = 2'($urandom());
      settle();
      if (!model_busy) begin
        winner = -1;
        if (pending[model_ptr] != 0) winner = model_ptr;
        else if (pending[1 - model_ptr] != 0) winner = 1 - model_ptr;
        check_output("rnd.req_ready", 32'(bus.req_ready),
                     (winner >= 0) ? (32'(1) << winner) : 32'(0));
        if (winner >= 0) begin
          check_output("rnd.starve", 32'(wait_turns[winner] <= 1), 32'(1));
          if (pending[1 - winner] != 0) wait_turns[1 - winner]++;
          model_idx   = winner;
          model_a     = op_a[winner];
          model_b     = op_b[winner];
          model_f     = op_f[winner];
          model_exp   = ref_alu(model_a, model_b, model_f);
          model_busy  = 1'b1;
          model_phase = 1;
          model_ptr   = 1 - winner;
          pending[winner] = 0;
          drop_idx    = winner;
        end
      end else if (model_phase == 1) begin
        check_output("rnd.exec_oe", 32'(alu_output_enable), 32'(1));
        check_output("rnd.exec_a", 32'(alu_operand_a), 32'(model_a));
        check_output("rnd.exec_b", 32'(alu_operand_b), 32'(model_b));
        check_output("rnd.exec_func", 32'(alu_func), 32'(model_f));
        check_output("rnd.exec_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        model_phase = 2;
      end else begin
        check_output("rnd.rsp_valid", 32'(bus.rsp_valid), 32'(1) << model_idx);
        check_output("rnd.rsp_result", 32'(bus.rsp_result), 32'(model_exp[7:0]));
        check_output("rnd.rsp_flags", 32'(bus.rsp_flags), 32'(model_exp[11:8]));
        check_output("rnd.resp_req_ready", 32'(bus.req_ready), 32'(0));
        if (bus.rsp_ready[model_idx]) begin
          model_busy = 1'b0;
          ops_done++;
        end
      end
      tick();
    end
    check_output("rnd.ops_done", 32'(ops_done), 32'(100));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ALU operand/result width.
REQ-002 SHALL have parameter N_REQ, default 2, number of requesters (2..4).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester accept.
REQ-007 SHALL have port req_a  input  N_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_b  input  N_REQ*DATA_W  operand B, same packing.
REQ-009 SHALL have port req_func  input  N_REQ*$bits(alu_func_e)  ALU function per requester.
REQ-010 SHALL have port rsp_valid  output  N_REQ  result available to requester i.
REQ-011 SHALL have port rsp_ready  input  N_REQ  requester i takes result.
REQ-012 SHALL have port rsp_result  output  DATA_W  captured ALU result, shared by all requesters.
REQ-013 SHALL have port rsp_flags  output  alu_flags_t  captured zero/positive/carry/signed_overflow.
REQ-014 SHALL have ports alu_operand_a, alu_operand_b  output  DATA_W  and alu_func  output  alu_func_e  driving the ALU.
REQ-015 SHALL have port alu_output_enable  output  1  ALU result bus enable.
REQ-016 SHALL have ports alu_result  input  DATA_W  and zero_flag, positive_flag, carry_flag, signed_overflow  input  1 each, from the ALU.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-018 In IDLE, req_ready SHALL be one-hot to the round-robin winner among asserted req_valid, else all zero; in EXEC/RESP req_ready SHALL be all zero.
REQ-019 Round-robin: search starts at priority pointer ptr, ascending with wrap N_REQ-1 -> 0; on accept ptr <= (grant+1) mod N_REQ.
REQ-020 On accept (cycle T) SHALL register grant index, operands and func; next state EXEC.
REQ-021 In EXEC (T+1) SHALL drive alu_operand_a/b/func from registers, alu_output_enable=1, capture alu_result and the four flags at end of cycle; next state RESP.
REQ-022 Outside EXEC alu_output_enable SHALL be 0 and alu_result (tristated) SHALL NOT be sampled; alu_operand_a/b/func SHALL hold their last values.
REQ-023 In RESP (T+2 onward) rsp_valid SHALL be one-hot at the granted index with rsp_result/rsp_flags stable, held until rsp_ready of that index is 1; then next state IDLE.
REQ-024 rsp_ready of non-granted indices SHALL be ignored; rsp_valid SHALL be all zero outside RESP.
REQ-025 Minimum issue-to-issue spacing SHALL be 3 cycles (accept, EXEC, RESP with immediate rsp_ready).
REQ-026 req_func SHALL pass through unmodified, including codes outside alu_func_e's named values.
REQ-027 Requesters SHALL keep req_valid and operands stable until accepted; dropping req_valid before accept withdraws the request without effect.

Reset
REQ-028 On rst: state IDLE, ptr 0, req_ready 0 until next evaluation, rsp_valid 0, rsp_result 0, rsp_flags 0, alu_operand_a/b 0, alu_func ADD, alu_output_enable 0.
REQ-029 rst in EXEC or RESP SHALL abort the operation; no rsp_valid SHALL follow for it.
REQ-030 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-031 alu_flags_t (packed: zero, positive, carry, signed_overflow) and the FSM state enum SHALL be added to alu_pkg; alu_func_e SHALL be reused from alu_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs request vector, ptr; outputs one-hot grant, grant index, any).

Verification
REQ-033 Bench SHALL instantiate alu_arbiter connected to alu (DATA_W=8, N_REQ=2).
REQ-034 Single req0: A=10h B=20h ADD, rsp_ready=1 -> req_ready[0] at T, alu_output_enable=1 only at T+1, rsp_valid[0] at T+2 with result 30h, flags Z0 P1 C0 O0.
REQ-035 Both requesting back-to-back after reset: req0 7Fh+01h ADD, req1 00h-01h SUB -> req0 granted first (result 80h, O=1), req1 next (result FFh, C per ALU), then req0 again (fairness alternates).
REQ-036 Backpressure: rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and result held stable, req_ready all 0, no second ALU enable; release -> IDLE next cycle.
REQ-037 rst asserted during EXEC of XOR AAh/55h -> no rsp_valid, outputs at reset values next cycle, ptr 0.
REQ-038 100 random ops from both requesters with random rsp_ready -> each response matches a reference model of alu and goes to the issuing requester, no request starved more than one turn.
